// File: rtl/mips32_mem_pkg.sv
// Shared types and constants for the MIPS32 unified-memory arbiter.
package mips32_mem_pkg;

  localparam int unsigned ADDR_W_DEF       = 10;
  localparam int unsigned DATA_W_DEF       = 32;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  // Bit positions of each requester in the request/grant vectors.
  localparam int unsigned IdxIf = 0;
  localparam int unsigned IdxDm = 1;
  localparam int unsigned IdxLd = 2;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_IF   = 2'd1,
    REQ_DM   = 2'd2,
    REQ_LD   = 2'd3
  } req_e;

  // Core opcodes that generate DM-stage traffic.
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2b;

  function automatic logic [2:0] req_onehot(req_e r);
    logic [2:0] v;
    v = 3'b000;
    case (r)
      REQ_IF:  v[IdxIf] = 1'b1;
      REQ_DM:  v[IdxDm] = 1'b1;
      REQ_LD:  v[IdxLd] = 1'b1;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mips32_prio_sel.sv
// Combinational priority table: LD (halted only) > promoted IF > DM > IF.
module mips32_prio_sel
  import mips32_mem_pkg::*;
(
  input  logic [2:0] elig_i,
  input  logic       promote_i,
  input  logic       halted_i,
  output logic [2:0] win_o
);

  always_comb begin
    win_o = 3'b000;
    if (halted_i && elig_i[IdxLd]) begin
      win_o[IdxLd] = 1'b1;
    end else if (promote_i && elig_i[IdxIf]) begin
      win_o[IdxIf] = 1'b1;
    end else if (elig_i[IdxDm]) begin
      win_o[IdxDm] = 1'b1;
    end else if (elig_i[IdxIf]) begin
      win_o[IdxIf] = 1'b1;
    end
  end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Sequences IF, DM and loader accesses onto one synchronous single-port SRAM,
// one access per cycle, with IF anti-starvation and fixed read latency.
module mips32_mem_arbiter
  import mips32_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk1_i,
  input  logic              rst_i,
  input  logic              cpu_halted_i,

  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,

  input  logic              dm_req_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic              dm_we_i,
  input  logic [DATA_W-1:0] dm_wdata_i,

  input  logic              ld_req_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic              ld_we_i,
  input  logic [DATA_W-1:0] ld_wdata_i,

  output logic              if_gnt_o,
  output logic              dm_gnt_o,
  output logic              ld_gnt_o,
  output logic              if_rvalid_o,
  output logic              dm_rvalid_o,
  output logic              ld_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic [DATA_W-1:0] ld_rdata_o,

  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [3:0] StarveLim = 4'(STARVE_LIMIT);

  logic [2:0]        gnt_q, rvalid_q, rvalid_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        starve_q, starve_d;
  req_e              tag_q, tag_d;

  logic [2:0] req, elig, win;
  logic       promote;

  assign req     = {ld_req_i, dm_req_i, if_req_i};
  // A requester still seeing its grant pulse must not be granted again.
  assign elig    = req & ~gnt_q;
  assign promote = (starve_q >= StarveLim);

  mips32_prio_sel u_prio_sel (
    .elig_i    (elig),
    .promote_i (promote),
    .halted_i  (cpu_halted_i),
    .win_o     (win)
  );

  always_comb begin
    mem_en_d    = |win;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    tag_d       = REQ_NONE;
    if (win[IdxLd]) begin
      mem_we_d    = ld_we_i;
      mem_addr_d  = ld_addr_i;
      mem_wdata_d = ld_wdata_i;
      tag_d       = ld_we_i ? REQ_NONE : REQ_LD;
    end else if (win[IdxDm]) begin
      mem_we_d    = dm_we_i;
      mem_addr_d  = dm_addr_i;
      mem_wdata_d = dm_wdata_i;
      tag_d       = dm_we_i ? REQ_NONE : REQ_DM;
    end else if (win[IdxIf]) begin
      mem_addr_d  = if_addr_i;
      tag_d       = REQ_IF;
    end
  end

  // SRAM data lands one edge after the grant, so rvalid follows the tag by one cycle.
  assign rvalid_d = req_onehot(tag_q);

  always_comb begin
    starve_d = starve_q;
    if (!if_req_i || win[IdxIf]) begin
      starve_d = 4'd0;
    end else if (elig[IdxIf] && (starve_q != 4'hF)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk1_i) begin
    if (rst_i) begin
      gnt_q       <= 3'b000;
      rvalid_q    <= 3'b000;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      starve_q    <= 4'd0;
      tag_q       <= REQ_NONE;
    end else begin
      gnt_q       <= win;
      rvalid_q    <= rvalid_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      starve_q    <= starve_d;
      tag_q       <= tag_d;
    end
  end

  assign if_gnt_o    = gnt_q[IdxIf];
  assign dm_gnt_o    = gnt_q[IdxDm];
  assign ld_gnt_o    = gnt_q[IdxLd];
  assign if_rvalid_o = rvalid_q[IdxIf];
  assign dm_rvalid_o = rvalid_q[IdxDm];
  assign ld_rvalid_o = rvalid_q[IdxLd];
  assign if_rdata_o  = mem_rdata_i;
  assign dm_rdata_o  = mem_rdata_i;
  assign ld_rdata_o  = mem_rdata_i;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Directed self-checking bench for mips32_mem_arbiter with a behavioural SRAM.
module tb_mips32_mem_arbiter;

  logic        clk, rst, cpu_halted;
  logic        if_req, dm_req, ld_req, dm_we, ld_we;
  logic [9:0]  if_addr, dm_addr, ld_addr;
  logic [31:0] dm_wdata, ld_wdata;
  logic        if_gnt, dm_gnt, ld_gnt, if_rvalid, dm_rvalid, ld_rvalid;
  logic [31:0] if_rdata, dm_rdata, ld_rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] mem [0:1023];

  logic [2:0] gnt_v, rv_v;
  assign gnt_v = {ld_gnt, dm_gnt, if_gnt};
  assign rv_v  = {ld_rvalid, dm_rvalid, if_rvalid};

  int n_checks = 0;
  int n_errors = 0;

  mips32_mem_arbiter dut (
    .clk1_i       (clk),
    .rst_i        (rst),
    .cpu_halted_i (cpu_halted),
    .if_req_i     (if_req),
    .if_addr_i    (if_addr),
    .dm_req_i     (dm_req),
    .dm_addr_i    (dm_addr),
    .dm_we_i      (dm_we),
    .dm_wdata_i   (dm_wdata),
    .ld_req_i     (ld_req),
    .ld_addr_i    (ld_addr),
    .ld_we_i      (ld_we),
    .ld_wdata_i   (ld_wdata),
    .if_gnt_o     (if_gnt),
    .dm_gnt_o     (dm_gnt),
    .ld_gnt_o     (ld_gnt),
    .if_rvalid_o  (if_rvalid),
    .dm_rvalid_o  (dm_rvalid),
    .ld_rvalid_o  (ld_rvalid),
    .if_rdata_o   (if_rdata),
    .dm_rdata_o   (dm_rdata),
    .ld_rdata_o   (ld_rdata),
    .mem_en_o     (mem_en),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port SRAM; one process owns the array.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
    mem[12]   = 32'hDEAD_BEEF;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else        mem_rdata     <= mem[mem_addr];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] exp_seq [12];
  logic [2:0] prev_g;

  initial begin
    rst = 1'b1; cpu_halted = 1'b0;
    if_req = 1'b0; dm_req = 1'b0; ld_req = 1'b0; dm_we = 1'b0; ld_we = 1'b0;
    if_addr = '0; dm_addr = '0; ld_addr = '0; dm_wdata = '0; ld_wdata = '0;
    step();
    step();
    check_eq("rst_gnt", 32'(gnt_v), 32'h0);
    check_eq("rst_rvalid", 32'(rv_v), 32'h0);
    check_eq("rst_mem_en_we", {30'h0, mem_en, mem_we}, 32'h0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'h0);
    check_eq("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;

    // Reset while a DM read is in flight.
    dm_req = 1'b1; dm_addr = 10'd5; dm_we = 1'b0;
    step();
    check_eq("midrd_dm_gnt", 32'(gnt_v), 32'b010);
    check_eq("midrd_mem_addr", 32'(mem_addr), 32'd5);
    check_eq("midrd_mem_en", 32'(mem_en), 32'd1);
    dm_req = 1'b0; rst = 1'b1;
    step();
    check_eq("midrd_rvalid", 32'(rv_v), 32'h0);
    check_eq("midrd_gnt", 32'(gnt_v), 32'h0);
    check_eq("midrd_mem", {21'h0, mem_en, mem_we, 9'h0} | 32'(mem_addr), 32'h0);
    rst = 1'b0;
    step();
    check_eq("midrd_post_rvalid", 32'(rv_v), 32'h0);

    // Uncontested IF read.
    if_req = 1'b1; if_addr = 10'd12;
    step();
    check_eq("unc_gnt", 32'(gnt_v), 32'b001);
    check_eq("unc_rvalid_early", 32'(rv_v), 32'h0);
    if_req = 1'b0;
    step();
    check_eq("unc_rvalid", 32'(rv_v), 32'b001);
    check_eq("unc_rdata", if_rdata, 32'hDEAD_BEEF);
    check_eq("unc_gnt_off", 32'(gnt_v), 32'h0);
    step();

    // Continuous IF+DM contention alternates DM, IF.
    if_req = 1'b1; if_addr = 10'd30;
    dm_req = 1'b1; dm_addr = 10'd20; dm_we = 1'b0;
    prev_g = 3'b000;
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq($sformatf("cont_gnt%0d", i), 32'(gnt_v), (i % 2 == 0) ? 32'b010 : 32'b001);
      check_eq($sformatf("cont_rv%0d", i), 32'(rv_v), 32'(prev_g));
      if (i > 0) begin
        check_eq($sformatf("cont_rdata%0d", i), (i % 2 == 1) ? dm_rdata : if_rdata,
                 (i % 2 == 1) ? 32'd20 : 32'd30);
      end
      prev_g = (i % 2 == 0) ? 3'b010 : 3'b001;
    end
    if_req = 1'b0; dm_req = 1'b0;
    step();
    step();

    // Halted: LD and DM alternate, IF is only served through promotion.
    exp_seq[0] = 3'b100; exp_seq[1] = 3'b010; exp_seq[2]  = 3'b100; exp_seq[3]  = 3'b010;
    exp_seq[4] = 3'b100; exp_seq[5] = 3'b001; exp_seq[6]  = 3'b100; exp_seq[7]  = 3'b010;
    exp_seq[8] = 3'b100; exp_seq[9] = 3'b010; exp_seq[10] = 3'b100; exp_seq[11] = 3'b001;
    cpu_halted = 1'b1;
    ld_req = 1'b1; ld_addr = 10'd40; ld_we = 1'b0;
    dm_req = 1'b1; dm_addr = 10'd41; dm_we = 1'b0;
    if_req = 1'b1; if_addr = 10'd42;
    for (int i = 0; i < 12; i++) begin
      step();
      check_eq($sformatf("starve_gnt%0d", i), 32'(gnt_v), 32'(exp_seq[i]));
    end
    ld_req = 1'b0; dm_req = 1'b0; if_req = 1'b0; cpu_halted = 1'b0;
    step();
    step();

    // Loader is locked out until the CPU halts.
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 10'd100; ld_wdata = 32'h0000_1234;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq($sformatf("ld_locked%0d", i), 32'(ld_gnt), 32'd0);
    end
    cpu_halted = 1'b1;
    step();
    check_eq("ld_gnt", 32'(gnt_v), 32'b100);
    check_eq("ld_we", 32'(mem_we), 32'd1);
    check_eq("ld_addr", 32'(mem_addr), 32'd100);
    check_eq("ld_wdata", mem_wdata, 32'h0000_1234);
    ld_req = 1'b0;
    step();
    check_eq("ld_wr_no_rvalid", 32'(rv_v), 32'h0);
    ld_req = 1'b1; ld_we = 1'b0;
    step();
    check_eq("ld_rd_gnt", 32'(gnt_v), 32'b100);
    ld_req = 1'b0;
    step();
    check_eq("ld_rd_rvalid", 32'(rv_v), 32'b100);
    check_eq("ld_rd_rdata", ld_rdata, 32'h0000_1234);
    cpu_halted = 1'b0;
    step();

    // Same-address DM write and IF read are serialised in priority order.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd7; dm_wdata = 32'hA5A5_A5A5;
    if_req = 1'b1; if_addr = 10'd7;
    step();
    check_eq("wr_rd_dm_first", 32'(gnt_v), 32'b010);
    check_eq("wr_rd_we", 32'(mem_we), 32'd1);
    dm_req = 1'b0;
    step();
    check_eq("wr_rd_if_next", 32'(gnt_v), 32'b001);
    check_eq("wr_rd_no_dm_rvalid", 32'(rv_v), 32'h0);
    if_req = 1'b0;
    step();
    check_eq("wr_rd_if_rvalid", 32'(rv_v), 32'b001);
    check_eq("wr_rd_if_rdata", if_rdata, 32'hA5A5_A5A5);

    // Top address reads back through the full address width.
    step();
    if_req = 1'b1; if_addr = 10'd1023;
    step();
    check_eq("top_addr", 32'(mem_addr), 32'd1023);
    if_req = 1'b0;
    step();
    check_eq("top_rdata", if_rdata, 32'd1023);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips32_mem_arbiter.md
# mips32_mem_arbiter

Sequences the single shared 1024 x 32 unified memory of the MIPS32 pipeline between three requesters: instruction fetch (IF), data memory stage (DM, LW/SW), and the program loader/debug port (LD). It sits between the pipeline stages and one synchronous single-port SRAM. It issues at most one access per cycle, arbitrates by priority with anti-starvation for IF, and returns read data with fixed latency. LD gets access only while the CPU is halted.

## Interface
- ADDR_W, 10, memory word-address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, number of consecutive denied IF cycles after which IF is promoted over DM (range 1-15)

- clk1  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_halted  in  1  HALTED flag from the write-back stage
- if_req / dm_req / ld_req  in  1  access request, held until granted
- if_addr / dm_addr / ld_addr  in  ADDR_W  word address, stable while req is high
- dm_we / ld_we  in  1  1 = write, 0 = read (IF is read-only)
- dm_wdata / ld_wdata  in  DATA_W  write data
- if_gnt / dm_gnt / ld_gnt  out  1  registered one-cycle grant pulse
- if_rvalid / dm_rvalid / ld_rvalid  out  1  read data valid pulse
- if_rdata / dm_rdata / ld_rdata  out  DATA_W  equal to mem_rdata; meaningful only with the matching rvalid
- mem_en, mem_we  out  1  SRAM enable and write strobe
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, valid one cycle after a read with mem_en=1

## Operation
**Eligibility:** A requester is eligible when its req is 1 and it was not granted in the previous cycle. The previous-cycle mask blocks a re-grant while the requester is still seeing its gnt.

**Priority when cpu_halted=0:**
- DM > IF.
- If starve_cnt >= STARVE_LIMIT, IF > DM.
- LD is never granted.

**Priority when cpu_halted=1:** LD > DM > IF, with the same IF promotion rule.

**Grant:**
- At each edge, the winner's command is registered onto mem_* and the matching gnt is set to 1 for exactly one cycle.
- If there is no winner, mem_en=0, mem_we=0, and all gnt are 0.

**Writes:**
- mem_we=1 in the gnt cycle.
- No rvalid is produced.

**Reads:**
- A 2-bit registered tag (pkg enum) records the reader.
- The matching rvalid pulses in the cycle after gnt, when mem_rdata is valid.

**starve_cnt (4-bit, saturating at 15):**
- +1 on each edge where IF is eligible but not granted.
- Cleared on an IF grant.
- Cleared when if_req=0.

**Boundary conditions:**
- cpu_halted falls while ld_req is pending: LD is not granted. LD waits; no timeout.
- cpu_halted rises with IF and DM both eligible: LD, if requesting, wins from that edge.
- Simultaneous read and write to the same address by different requesters: serialised in priority order, with no reordering.
- Address bits above ADDR_W do not exist; the address wraps naturally at 1023 -> 0 on the requester side.

**Reset:**
- mem_en, mem_we, all gnt, all rvalid, starve_cnt, the previous-grant mask and the read tag are 0.
- mem_addr and mem_wdata are 0.
- A read in flight at reset produces no rvalid.

## Timing
- Grant latency: 1 cycle from the first edge at which req is sampled eligible and wins.
- Read latency: rvalid 2 cycles after req is first sampled, for an uncontested request.
- Throughput: one access per cycle overall; one access per 2 cycles per requester (mask rule).
- A DM read granted in cycle n and an IF read granted in cycle n+1 give dm_rvalid at n+1 and if_rvalid at n+2.
- starve_cnt is evaluated on the registered value at the arbitration edge. Promotion therefore takes effect on the edge after the count reaches STARVE_LIMIT.

## Structure
- Package mips32_mem_pkg:
  - ADDR_W/DATA_W defaults
  - requester enum (REQ_NONE, REQ_IF, REQ_DM, REQ_LD, 2 bits)
  - opcode constants reused from the core
- One sub-module, mips32_prio_sel: purely combinational.
  - Inputs: eligibility vector, promote flag, halted.
  - Output: one-hot winner.
  - Lets the priority table be verified standalone.
- Top-level holds the mask, tag, starve counter and output registers.

## Test plan
- Reset mid-read: DM read to addr 5 granted, rst asserted in the rvalid cycle -> dm_rvalid=0, all outputs 0 the next cycle.
- Uncontested read: IF read addr 12 (mem[12]=0xDEADBEEF) -> if_gnt at +1, if_rvalid with if_rdata=0xDEADBEEF at +2.
- Contention: IF and DM continuously requesting, STARVE_LIMIT=4 -> DM is granted every other cycle. IF is never denied long enough to promote; check the grant sequence DM, IF, DM, IF.
- Starvation: DM requesting every cycle, alternating requests from two DM-path sources modelled as back-to-back new requests with the mask bypassed by a fresh req, plus IF held -> IF is granted no later than the 5th edge after its req rises; starve_cnt returns to 0.
- Halt/loader: cpu_halted=0, ld_req write addr 100 data 0x1234 -> no ld_gnt for 10 cycles. Raise cpu_halted -> ld_gnt next edge, mem_we=1, mem_addr=100. A subsequent LD read of 100 returns 0x1234.
- Write/read ordering: DM write addr 7 = 0xA5A5A5A5 and IF read addr 7 asserted in the same cycle -> DM granted first, IF granted the next cycle and returns 0xA5A5A5A5.
